// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the VRAM display/host arbiter.
package vram_arb_pkg;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 15;

  // IDLE: no host access, PEND: host request latched and waiting for the port,
  // RDWAIT: host read issued last cycle, RAM data arrives this cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  // Width of the host wait counter; never narrower than one bit.
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the display readout owns the port by default and
// a host access steals it when the display is quiet or has starved the host
// for MAX_WAIT cycles.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              nrst,
  // display readout port
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic [DATA_W-1:0] dispRdData,
  output logic              dispRdValid,
  // host access port
  input  logic              hostReq,
  input  logic              hostWe,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWrData,
  output logic              hostBusy,
  output logic              hostDone,
  output logic [DATA_W-1:0] hostRdData,
  output logic              hostStarved,
  // VRAM port
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramWrData,
  input  logic [DATA_W-1:0] ramRdData
);

  localparam int              CNT_W   = wait_cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              done_q,    done_d;
  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              starved_q, starved_d;

  logic wait_full;
  logic host_grant;

  // The counter saturating at MAX_WAIT is what forces the host through.
  assign wait_full  = (cnt_q == CNT_MAX);
  assign host_grant = (state_q == ST_PEND) && (!dispReq || wait_full);

  // Next-state logic and the combinational VRAM port mux.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    starved_d = starved_q;
    ramAddr   = dispAddr;
    ramWe     = 1'b0;
    ramWrData = wdata_q;

    // The display only gets data back when it actually owned the port.
    valid_d = dispReq && !host_grant;

    case (state_q)
      ST_IDLE: begin
        if (hostReq) begin
          we_d    = hostWe;
          addr_d  = hostAddr;
          wdata_d = hostWrData;
          cnt_d   = '0;
          state_d = ST_PEND;
        end
      end

      ST_PEND: begin
        if (host_grant) begin
          ramAddr = addr_q;
          ramWe   = we_q;
          // Granting while the display still wants the port means it was starved.
          if (dispReq) begin
            starved_d = 1'b1;
          end
          if (we_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RDWAIT;
          end
        end else if (!wait_full) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RDWAIT: begin
        // RAM data for the host address issued last cycle is present now.
        rdata_d = ramRdData;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and all held/registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      starved_q <= starved_d;
    end
  end

  assign dispRdData  = ramRdData;
  assign dispRdValid = valid_q;
  assign hostBusy    = (state_q != ST_IDLE);
  assign hostDone    = done_q;
  assign hostRdData  = rdata_q;
  assign hostStarved = starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          dispReq = 1'b0;
  logic [AW-1:0] dispAddr = '0;
  logic [DW-1:0] dispRdData;
  logic          dispRdValid;
  logic          hostReq = 1'b0;
  logic          hostWe = 1'b0;
  logic [AW-1:0] hostAddr = '0;
  logic [DW-1:0] hostWrData = '0;
  logic          hostBusy;
  logic          hostDone;
  logic [DW-1:0] hostRdData;
  logic          hostStarved;
  logic [AW-1:0] ramAddr;
  logic          ramWe;
  logic [DW-1:0] ramWrData;
  logic [DW-1:0] ramRdData = '0;

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  vram_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .dispReq    (dispReq),
    .dispAddr   (dispAddr),
    .dispRdData (dispRdData),
    .dispRdValid(dispRdValid),
    .hostReq    (hostReq),
    .hostWe     (hostWe),
    .hostAddr   (hostAddr),
    .hostWrData (hostWrData),
    .hostBusy   (hostBusy),
    .hostDone   (hostDone),
    .hostRdData (hostRdData),
    .hostStarved(hostStarved),
    .ramAddr    (ramAddr),
    .ramWe      (ramWe),
    .ramWrData  (ramWrData),
    .ramRdData  (ramRdData)
  );

  always #5 clk = ~clk;

  // Power-on contents of every VRAM word that has never been written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[12:5] ^ 8'h3C;
  endfunction

  // Synchronous single-port VRAM: read data one cycle after the address.
  logic [DW-1:0] vram [logic [AW-1:0]];
  always @(posedge clk) begin
    ramRdData <= vram.exists(ramAddr) ? vram[ramAddr] : init_val(ramAddr);
    if (ramWe && nrst) vram[ramAddr] = ramWrData;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            m_out;      // host request accepted, not yet granted
  bit            m_rd;       // host read granted last cycle
  int            m_waited;   // cycles the display has beaten the host
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_done;
  bit            m_valid;
  bit            m_starved;
  logic [DW-1:0] m_hrd;
  logic [DW-1:0] m_rd_pend;
  logic [DW-1:0] m_disp_exp;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_out = 0; m_rd = 0; m_waited = 0; m_we = 0; m_addr = '0; m_data = '0;
    m_done = 0; m_valid = 0; m_starved = 0; m_hrd = '0; m_rd_pend = '0;
    m_disp_exp = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output, advance the model.
  task automatic step(input bit dr, input logic [AW-1:0] da, input bit hr,
                      input bit hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    bit grant;
    bit accept;
    @(negedge clk);
    dispReq = dr; dispAddr = da; hostReq = hr; hostWe = hw; hostAddr = ha; hostWrData = hd;
    #1;
    grant  = m_out && (!dr || m_waited >= MW);
    accept = hr && !m_out && !m_rd;
    chk("ramAddr", 32'(ramAddr), 32'(grant ? m_addr : da));
    chk("ramWe", 32'(ramWe), 32'(grant && m_we));
    if (grant && m_we) chk("ramWrData", 32'(ramWrData), 32'(m_data));
    chk("hostBusy", 32'(hostBusy), 32'(m_out || m_rd));
    chk("hostDone", 32'(hostDone), 32'(m_done));
    chk("dispRdValid", 32'(dispRdValid), 32'(m_valid));
    if (m_valid) chk("dispRdData", 32'(dispRdData), 32'(m_disp_exp));
    chk("hostRdData", 32'(hostRdData), 32'(m_hrd));
    chk("hostStarved", 32'(hostStarved), 32'(m_starved));
    if (hostDone) n_done++;

    m_valid    = dr && !grant;
    m_disp_exp = ref_rd(da);
    m_done     = 0;
    if (m_rd) begin
      m_hrd  = m_rd_pend;
      m_done = 1;
      m_rd   = 0;
    end
    if (grant) begin
      if (dr) m_starved = 1;
      m_out = 0;
      if (m_we) begin
        ref_mem[m_addr] = m_data;
        m_done = 1;
      end else begin
        m_rd      = 1;
        m_rd_pend = ref_rd(m_addr);
      end
    end else if (m_out) begin
      m_waited++;
    end
    if (accept) begin
      m_out = 1; m_waited = 0; m_we = hw; m_addr = ha; m_data = hd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 13'h0100, 0, 0, '0, '0);
  endtask

  // Assert reset between clock edges, check reset values, release.
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; dispReq = 1'b0; hostReq = 1'b0;
    #1;
    chk("rst_hostBusy", 32'(hostBusy), 32'd0);
    chk("rst_hostDone", 32'(hostDone), 32'd0);
    chk("rst_dispRdValid", 32'(dispRdValid), 32'd0);
    chk("rst_hostRdData", 32'(hostRdData), 32'd0);
    chk("rst_hostStarved", 32'(hostStarved), 32'd0);
    chk("rst_ramWe", 32'(ramWe), 32'd0);
    chk("rst_ramAddr", 32'(ramAddr), 32'(dispAddr));
    @(negedge clk);
    #1;
    chk("rst_ramWe_hold", 32'(ramWe), 32'd0);
    chk("rst_hostBusy_hold", 32'(hostBusy), 32'd0);
    nrst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle display: host write then read-back.
    step(0, 13'h0100, 1, 1, 13'h0123, 8'hA5);
    idle(3);
    step(0, 13'h0100, 1, 0, 13'h0123, 8'h00);
    idle(3);
    chk("readback_0123", 32'(hostRdData), 32'h0000_00A5);

    // Display hogs the port: host read must be forced through after MAX_WAIT.
    step(1, 13'h0040, 1, 0, 13'h0010, 8'h00);
    for (int i = 0; i < 20; i++) step(1, AW'(13'h0040 + i), 0, 0, '0, '0);
    chk("starved_set", 32'(hostStarved), 32'd1);
    chk("forced_read_data", 32'(hostRdData), 32'(init_val(13'h0010)));

    // Display toggling: host read slips in on the first quiet cycle.
    step(1, 13'h0050, 1, 0, 13'h0123, 8'h00);
    for (int i = 0; i < 8; i++) step((i % 2) == 0, 13'h0060, 0, 0, '0, '0);
    chk("toggle_read_data", 32'(hostRdData), 32'h0000_00A5);

    // Second request while busy is ignored.
    n_done = 0;
    step(0, 13'h0100, 1, 0, 13'h0300, 8'h00);
    step(1, 13'h0101, 1, 1, 13'h0777, 8'h11);
    step(1, 13'h0102, 1, 1, 13'h0777, 8'h11);
    idle(5);
    chk("single_done", 32'(n_done), 32'd1);

    // Reset in PEND aborts the write without a done pulse.
    n_done = 0;
    step(1, 13'h0200, 1, 1, 13'h0400, 8'h77);
    step(1, 13'h0201, 0, 0, '0, '0);
    step(1, 13'h0202, 0, 0, '0, '0);
    do_reset();
    idle(4);
    chk("abort_no_done", 32'(n_done), 32'd0);
    step(0, 13'h0100, 1, 1, 13'h0400, 8'h99);
    idle(3);
    step(0, 13'h0100, 1, 0, 13'h0400, 8'h00);
    idle(3);
    chk("after_reset_rw", 32'(hostRdData), 32'h0000_0099);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
             $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 63)), DW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, VRAM word-address width.
REQ-002 Parameter DATA_W, default 8, VRAM data width.
REQ-003 Parameter MAX_WAIT, default 15, host wait cycles before forced grant.
REQ-004 clk  in  1  pixel clock; single clock domain, all state on rising edge.
REQ-005 nrst  in  1  reset, asynchronous assert, active-low.
REQ-006 dispReq  in  1  display readout requests a VRAM read this cycle.
REQ-007 dispAddr  in  ADDR_W  display read address.
REQ-008 dispRdData  out  DATA_W  display read data, combinational pass-through of ramRdData.
REQ-009 dispRdValid  out  1  dispRdData is valid for the display request of the previous cycle.
REQ-010 hostReq  in  1  one-cycle host access request strobe.
REQ-011 hostWe  in  1  host request is a write (1) or read (0), sampled with hostReq.
REQ-012 hostAddr  in  ADDR_W  host address, sampled with hostReq.
REQ-013 hostWrData  in  DATA_W  host write data, sampled with hostReq.
REQ-014 hostBusy  out  1  host request pending or in flight.
REQ-015 hostDone  out  1  one-cycle pulse on host access completion.
REQ-016 hostRdData  out  DATA_W  last completed host read data, held.
REQ-017 hostStarved  out  1  sticky flag: a forced host grant has occurred.
REQ-018 ramAddr  out  ADDR_W  single-port VRAM address.
REQ-019 ramWe  out  1  VRAM write enable.
REQ-020 ramWrData  out  DATA_W  VRAM write data.
REQ-021 ramRdData  in  DATA_W  VRAM read data, valid one cycle after address.

Function
REQ-022 FSM states: IDLE, PEND, RDWAIT; hostReq in IDLE latches hostWe/hostAddr/hostWrData and enters PEND.
REQ-023 hostReq outside IDLE is ignored; latched request unchanged.
REQ-024 In PEND, display wins: dispReq=1 drives ramAddr=dispAddr, ramWe=0; host waits and wait counter increments.
REQ-025 In PEND with dispReq=0, or wait counter = MAX_WAIT, host is granted: ramAddr=latched address, ramWe=latched hostWe, ramWrData=latched data.
REQ-026 Host grant in cycle N: write -> IDLE, hostDone=1 in N+1; read -> RDWAIT in N+1, capture ramRdData into hostRdData at end of N+1, hostDone=1 in N+2.
REQ-027 Forced grant (dispReq=1 and counter = MAX_WAIT) sets hostStarved; dispRdValid=0 in the following cycle.
REQ-028 dispRdValid = registered (dispReq and display granted); latency exactly 1 cycle.
REQ-029 With no grant and no dispReq: ramWe=0, ramAddr=dispAddr.
REQ-030 hostBusy=1 from cycle after accepted hostReq until the cycle before hostDone; a new hostReq is accepted in the hostDone cycle.
REQ-031 Wait counter is ceil(log2(MAX_WAIT+1)) bits, cleared on entering PEND, saturates at MAX_WAIT.
REQ-032 ramWe is never asserted outside a host write grant.

Reset
REQ-033 nrst low: state=IDLE, wait counter=0, hostBusy=0, hostDone=0, dispRdValid=0, hostRdData=0, hostStarved=0, latched request=0.
REQ-034 Reset mid-access aborts the pending/in-flight host access without hostDone; ramWe=0 during reset.

Structure
REQ-035 Package vram_arb_pkg holds the FSM state enum and default ADDR_W/DATA_W constants.
REQ-036 Single module, no sub-modules; the address/write mux is combinational from FSM state and dispReq.

Verification
REQ-037 Idle display, host write 0x0123<-0xA5 -> ramWe=1 next cycle, hostDone one cycle later, read-back returns 0xA5.
REQ-038 dispReq held high, host read 0x0010, MAX_WAIT=15 -> host granted on 16th PEND cycle, hostStarved=1, dispRdValid=0 once.
REQ-039 dispReq toggling 1,0 -> host read granted at first dispReq=0 cycle, hostDone 2 cycles after grant, hostRdData correct.
REQ-040 hostReq while hostBusy -> ignored, exactly one hostDone, second address never on ramAddr.
REQ-041 nrst low during PEND -> IDLE, no hostDone, all outputs at reset values, next hostReq serviced normally.
